dst_serializer: RTL and testbench



---
 rtl/dst_serializer_pkg.sv | 27 ++
 rtl/dst_serializer.sv | 103 ++++++++++
 tb/tb_dst_serializer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dst_serializer_pkg.sv
// rtl/dst_serializer_pkg.sv - shared types and frame-length helper for dst_serializer
//
// Purpose: state encoding, the default output count and the frame length.
// Configuration: the DST_SERIALIZER_PARITY_EN macro appends one even-parity
// bit to every frame, so a frame is one bit longer.
// Ports: none (package).

package dst_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Number of single-bit outputs of the square32 compressor.
    localparam int DEFAULT_NUM_DST = 37;

    // Bits per serial frame for a given number of compressor outputs.
    function automatic int frame_len(input int num_dst);
`ifdef DST_SERIALIZER_PARITY_EN
        return num_dst + 1;
`else
        return num_dst;
`endif
    endfunction

endpackage

// File: rtl/dst_serializer.sv
// rtl/dst_serializer.sv - parallel-capture, LSB-first serializer for compressor outputs
//
// Purpose: captures NUM_DST compressor output bits on load&&ready and shifts
// them out one per clock on sout, with frame_start/frame_end strobes.
// Configuration: DST_SERIALIZER_PARITY_EN appends an even-parity bit after
// dst[NUM_DST-1]; frame_end then marks the parity bit.
// Ports:
//   clk          in   clock, all state on posedge
//   rst          in   asynchronous active-high reset
//   dst          in   [NUM_DST] parallel results, sampled only on acceptance
//   load         in   capture dst and start a frame (honoured when ready)
//   ready        out  a load would be accepted this cycle
//   sout         out  serial data bit (register-sourced)
//   sout_valid   out  sout carries a frame bit this cycle
//   frame_start  out  first bit of a frame
//   frame_end    out  last bit of a frame

module dst_serializer
    import dst_serializer_pkg::*;
#(
    parameter int NUM_DST = DEFAULT_NUM_DST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_DST-1:0] dst,
    input  logic               load,
    output logic               ready,
    output logic               sout,
    output logic               sout_valid,
    output logic               frame_start,
    output logic               frame_end
);

    localparam int FRAME_LEN = frame_len(NUM_DST);
    localparam int CNT_W     = $clog2(NUM_DST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [FRAME_LEN-1:0] r_shreg;
    logic [CNT_W-1:0]     r_cnt;
    logic [FRAME_LEN-1:0] w_load_word;
    logic                 w_last;
    logic                 w_accept;

`ifdef DST_SERIALIZER_PARITY_EN
    // Parity bit sits above dst so it leaves the shifter right after dst[NUM_DST-1];
    // XOR of all bits makes the total count of ones in the frame even.
    assign w_load_word = {^dst, dst};
`else
    assign w_load_word = dst;
`endif

    assign w_last   = (r_state == SHIFT) && (r_cnt == LAST_CNT);
    // Accepting during the last bit lets frames stream back to back.
    assign ready    = (r_state == IDLE) || w_last;
    assign w_accept = load && ready;

    assign sout        = r_shreg[0];
    assign sout_valid  = (r_state == SHIFT);
    assign frame_start = (r_state == SHIFT) && (r_cnt == '0);
    assign frame_end   = w_last;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last && !w_accept) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shreg <= w_load_word;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            // Zero fill leaves the shifter cleared once a frame drains, so sout idles low.
            r_shreg <= r_shreg >> 1;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dst_serializer.sv
// tb/tb_dst_serializer.sv - directed self-checking bench for dst_serializer

module tb_dst_serializer;

    localparam int N   = 37;
    localparam int FL  = dst_serializer_pkg::frame_len(N);
    localparam int FL1 = dst_serializer_pkg::frame_len(1);

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] dst;
    logic         load;
    logic         ready, sout, sout_valid, frame_start, frame_end;
    logic [0:0]   dst1;
    logic         load1;
    logic         ready1, sout1, sout_valid1, frame_start1, frame_end1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dst_serializer #(.NUM_DST(N)) u_dut (
        .clk(clk), .rst(rst), .dst(dst), .load(load), .ready(ready),
        .sout(sout), .sout_valid(sout_valid),
        .frame_start(frame_start), .frame_end(frame_end)
    );

    dst_serializer #(.NUM_DST(1)) u_dut1 (
        .clk(clk), .rst(rst), .dst(dst1), .load(load1), .ready(ready1),
        .sout(sout1), .sout_valid(sout_valid1),
        .frame_start(frame_start1), .frame_end(frame_end1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected frame bit i: dst bits LSB first, then (parity build) XOR of dst.
    function automatic logic exp_bit(input logic [N-1:0] d, input int i);
        logic [N:0] w;
        w = {^d, d};
        return w[i];
    endfunction

    task automatic chk_bit(input string t, input int i, input logic [N-1:0] d);
        chk($sformatf("%s_b%0d_sout", t, i), sout, exp_bit(d, i));
        chk($sformatf("%s_b%0d_valid", t, i), sout_valid, 1'b1);
        chk($sformatf("%s_b%0d_fstart", t, i), frame_start, i == 0);
        chk($sformatf("%s_b%0d_fend", t, i), frame_end, i == FL - 1);
        chk($sformatf("%s_b%0d_ready", t, i), ready, i == FL - 1);
    endtask

    task automatic chk_idle(input string t);
        chk({t, "_idle_valid"}, sout_valid, 1'b0);
        chk({t, "_idle_sout"}, sout, 1'b0);
        chk({t, "_idle_fstart"}, frame_start, 1'b0);
        chk({t, "_idle_fend"}, frame_end, 1'b0);
        chk({t, "_idle_ready"}, ready, 1'b1);
    endtask

    initial begin
        logic [N-1:0] d;
        rst   = 1'b1;
        load  = 1'b0;
        dst   = '0;
        load1 = 1'b0;
        dst1  = '0;
        step();
        step();
        chk_idle("reset");
        chk("reset_ready1", ready1, 1'b1);
        chk("reset_valid1", sout_valid1, 1'b0);
        #2 rst = 1'b0;
        step();

        // Single frame, hand pattern: bits 1,0,0,1,0,0,0,1,...
        d = 37'h0_2345_6789;
        dst = d; load = 1'b1;
        step();
        load = 1'b0; dst = '0;
        chk("t1_bit0_literal", sout, 1'b1);
        for (int i = 0; i < FL; i++) begin
            chk_bit("t1", i, d);
            step();
        end
        chk_idle("t1");

        // Back to back: load held high, all ones then all zeros.
        dst = '1; load = 1'b1;
        step();
        for (int i = 0; i < FL; i++) begin
            if (i == 1) dst = '0;
            chk_bit("t2a", i, '1);
            step();
        end
        for (int i = 0; i < FL; i++) begin
            load = 1'b0;
            chk_bit("t2b", i, '0);
            step();
        end
        chk_idle("t2");

        // Loads during an active frame are ignored.
        d = 37'h1_5555_AAAA;
        dst = d; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < FL; i++) begin
            dst  = 37'h0_FFFF_0000;
            load = (i == 4) || (i == 19);
            chk_bit("t3", i, d);
            step();
        end
        load = 1'b0;
        chk_idle("t3");

        // Asynchronous reset during bit 10.
        d = 37'h1A_BCDE_F3FF;
        dst = d; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk_bit("t4", i, d);
            if (i < 9) step();
        end
        #2 rst = 1'b1;
        #1;
        chk_idle("t4_inrst");
        #1 rst = 1'b0;
        step();
        chk_idle("t4_post");
        d = 37'h0_F0F0_1234;
        dst = d; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < FL; i++) begin
            chk_bit("t4n", i, d);
            step();
        end
        chk_idle("t4n");

        // NUM_DST=1 instance.
        dst1 = 1'b1; load1 = 1'b1;
        step();
        load1 = 1'b0;
        for (int i = 0; i < FL1; i++) begin
            chk($sformatf("t5_b%0d_sout", i), sout1, 1'b1);
            chk($sformatf("t5_b%0d_valid", i), sout_valid1, 1'b1);
            chk($sformatf("t5_b%0d_fstart", i), frame_start1, i == 0);
            chk($sformatf("t5_b%0d_fend", i), frame_end1, i == FL1 - 1);
            step();
        end
        chk("t5_idle_valid", sout_valid1, 1'b0);
        chk("t5_idle_ready", ready1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
